// File: rtl/argmax_pkg.sv
// Shared definitions for the streaming argmax block: FSM state encoding
// and the index-width helper used to size out_index.
package argmax_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width needed to hold an index in 0..n-1, never less than one bit.
   function automatic int idx_w(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Strict greater-than compare of two scores, signed or unsigned by parameter.
module argmax_cmp #(
   parameter int SCORE_W = 8,
   parameter bit SIGNED  = 1'b0
) (
   input  logic [SCORE_W-1:0] a,
   input  logic [SCORE_W-1:0] b,
   output logic               gt
);

   generate
      if (SIGNED) begin : g_signed
         assign gt = ($signed(a) > $signed(b));
      end else begin : g_unsigned
         assign gt = (a > b);
      end
   endgenerate

endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax: consumes one score beat per cycle, tracks the top-1 and
// top-2 scores of a frame and presents index, score, margin and a length
// error flag once the in_last beat has been accepted.
module argmax_stream
   import argmax_pkg::*;
#(
   parameter int N_CLASSES = 10,
   parameter int SCORE_W   = 8,
   parameter bit SIGNED    = 1'b0,
   localparam int IDX_W    = idx_w(N_CLASSES)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SCORE_W-1:0] in_score,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [IDX_W-1:0]   out_index,
   output logic [SCORE_W-1:0] out_score,
   output logic [SCORE_W-1:0] out_margin,
   output logic               out_err
);

   // Counter must be able to hold N_CLASSES itself (saturation value).
   localparam int CNT_W = $clog2(N_CLASSES + 1);
   localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_CLASSES);

   state_t             state, state_n;
   logic [SCORE_W-1:0] best, best_n;
   logic [SCORE_W-1:0] second, second_n;
   logic               has_second, has_second_n;
   logic [IDX_W-1:0]   best_idx, idx_n;
   logic [CNT_W-1:0]   count, count_n;
   logic               over, over_n;
   logic               accept, consume;
   logic               gt_best, gt_second;
   logic [SCORE_W:0]   best_x, second_x;
   logic [SCORE_W-1:0] margin_n;
   logic               err_n;

   assign accept  = in_valid & in_ready;
   assign consume = out_valid & out_ready;

   argmax_cmp #(.SCORE_W(SCORE_W), .SIGNED(SIGNED)) u_cmp_best (
      .a  (in_score),
      .b  (best),
      .gt (gt_best)
   );

   argmax_cmp #(.SCORE_W(SCORE_W), .SIGNED(SIGNED)) u_cmp_second (
      .a  (in_score),
      .b  (second),
      .gt (gt_second)
   );

   // Next FSM state from handshakes.
   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_n = in_last ? DONE : ACC;
            end else begin
               state_n = IDLE;
            end
         end
         ACC: begin
            if (accept && in_last) begin
               state_n = DONE;
            end else begin
               state_n = ACC;
            end
         end
         DONE: begin
            if (consume) begin
               state_n = IDLE;
            end else begin
               state_n = DONE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Top-1/top-2 update for the beat presented this cycle; beats past the
   // last class index only bump the overflow flag.
   always_comb begin
      best_n       = best;
      second_n     = second;
      has_second_n = has_second;
      idx_n        = best_idx;
      count_n      = count;
      over_n       = over;
      if (state == IDLE) begin
         best_n       = in_score;
         second_n     = '0;
         has_second_n = 1'b0;
         idx_n        = '0;
         count_n      = CNT_W'(1);
         over_n       = 1'b0;
      end else if (count < N_CNT) begin
         count_n = count + CNT_W'(1);
         if (gt_best) begin
            second_n     = best;
            has_second_n = 1'b1;
            best_n       = in_score;
            idx_n        = count[IDX_W-1:0];
         end else if (!has_second || gt_second) begin
            second_n     = in_score;
            has_second_n = 1'b1;
         end else begin
            second_n     = second;
         end
      end else begin
         over_n = 1'b1;
      end
   end

   // Margin is taken one bit wider so a full-range signed spread still
   // yields the correct unsigned difference after truncation.
   always_comb begin
      if (SIGNED) begin
         best_x   = {best_n[SCORE_W-1], best_n};
         second_x = {second_n[SCORE_W-1], second_n};
      end else begin
         best_x   = {1'b0, best_n};
         second_x = {1'b0, second_n};
      end
      margin_n = has_second_n ? SCORE_W'(best_x - second_x) : '0;
      err_n    = (count_n != N_CNT) || over_n;
   end

   // FSM, running frame state and registered result/handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         best       <= '0;
         second     <= '0;
         has_second <= 1'b0;
         best_idx   <= '0;
         count      <= '0;
         over       <= 1'b0;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         out_index  <= '0;
         out_score  <= '0;
         out_margin <= '0;
         out_err    <= 1'b0;
      end else begin
         state     <= state_n;
         in_ready  <= (state_n != DONE);
         out_valid <= (state_n == DONE);
         if (accept) begin
            best       <= best_n;
            second     <= second_n;
            has_second <= has_second_n;
            best_idx   <= idx_n;
            count      <= count_n;
            over       <= over_n;
            if (in_last) begin
               out_index  <= idx_n;
               out_score  <= best_n;
               out_margin <= margin_n;
               out_err    <= err_n;
            end
         end
      end
   end

endmodule

// File: doc/argmax_stream.md
ARGMAX_STREAM -- requirements
Module: argmax_stream

Interface
REQ-001 Parameter N_CLASSES, default 10: number of score beats per frame, minimum 2.
REQ-002 Parameter SCORE_W, default 8: score width in bits.
REQ-003 Parameter SIGNED, default 0: 1 compares scores as two's complement, 0 as unsigned.
REQ-004 Derived constant IDX_W = max(1, clog2(N_CLASSES)), fixed and not overridable.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 in_valid  input  1  in_score and in_last are valid this cycle.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 in_score  input  SCORE_W  class score; beat k of a frame is class index k.
REQ-010 in_last  input  1  marks the final beat of a frame.
REQ-011 out_valid  output  1  result is valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_index  output  IDX_W  index of the maximum score.
REQ-014 out_score  output  SCORE_W  maximum score value.
REQ-015 out_margin  output  SCORE_W  top-1 minus top-2, unsigned.
REQ-016 out_err  output  1  frame beat count was not N_CLASSES.

Function
REQ-017 A beat is accepted on a rising edge with in_valid=1 and in_ready=1; a result is consumed on a rising edge with out_valid=1 and out_ready=1.
REQ-018 FSM states: IDLE, ACC, DONE.
- IDLE -> ACC on an accepted beat with in_last=0.
- IDLE -> DONE on an accepted beat with in_last=1.
- ACC -> DONE on an accepted beat with in_last=1.
- DONE -> IDLE on result consumption.
REQ-019 in_ready = 1 in IDLE and ACC, 0 in DONE; out_valid = 1 only in DONE.
REQ-020 The first beat of a frame loads best = in_score, best index = 0, second = none, beat count = 1.
REQ-021 On each later beat k, when in_score > best (strictly greater):
- second takes the old best;
- best takes in_score;
- best index takes k.
REQ-022 On each later beat k, when in_score <= best and (second is none or in_score > second), second takes in_score.
REQ-023 Ties keep the lowest index: an equal score never replaces best.
REQ-024 Comparisons use signed arithmetic when SIGNED=1 and unsigned when SIGNED=0.
REQ-025 out_margin is best minus second, computed in SCORE_W+1 bits and truncated to SCORE_W bits (always non-negative).
REQ-026 out_margin = 0 when second is none.
REQ-027 The beat counter saturates at N_CLASSES.
REQ-028 Beats past index N_CLASSES-1 are still accepted but are excluded from the compare, and out_index never exceeds N_CLASSES-1.
REQ-029 out_err = 1 when the frame's accepted beat count differs from N_CLASSES (short or long frame).
REQ-030 Latency: out_valid rises on the rising edge that accepts the in_last beat, so outputs are valid in the following cycle.
REQ-031 out_index, out_score, out_margin and out_err are registered and held stable while out_valid=1 and out_ready=0.
REQ-032 When out_ready=1 and in_valid=1 in the same DONE cycle, only the result is consumed; the new beat is accepted in the next IDLE cycle.
REQ-033 Throughput: one beat per cycle; one idle cycle between frames.

Reset
REQ-034 rst_n low asynchronously forces state IDLE and clears the counter, best, second and all result registers.
REQ-035 During reset, every output is 0 except in_ready, which is 1 once reset is released.
REQ-036 A reset mid-frame discards the partial frame; no result is emitted.

Structure
REQ-037 Package argmax_pkg holds the FSM state enum and the clog2-based IDX_W helper function.
REQ-038 Sub-module argmax_cmp holds the parametrised SIGNED greater-than compare, instantiated twice (against best and against second).

Verification
REQ-039 SIGNED=0, scores 3,9,1,9,0,2,7,5,8,4 with last on beat 9 -> index 1, score 9, margin 0, err 0.
REQ-040 SIGNED=1, scores -128,-5,-6,-100,-7,-9,-20,-30,-40,-50 -> index 1, score -5 (8'hFB), margin 1.
REQ-041 SIGNED=0, scores 0..9 ascending -> index 9, score 9, margin 1; out_ready held low for 5 cycles -> outputs stable and in_ready=0 throughout.
REQ-042 Short frame of 4 beats 10,20,5,1 -> index 1, score 20, margin 10, err 1; then a 12-beat frame -> err 1 and index <= 9.
REQ-043 Reset asserted after beat 5 of a frame, then a full 10-beat frame with max 200 at beat 7 -> exactly one result, index 7, score 200.
REQ-044 Back-to-back frames with out_ready tied high -> in_ready low for exactly one cycle between frames and no beat lost.
